// File: rtl/pipeline_hazard_ctrl_if.sv
// Control bundle between the 5-stage pipeline datapath and its hazard/sequencing controller.
interface pipeline_hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       IFID_rs1;
    logic [4:0]       IFID_rs2;
    logic             IFID_use_rs1;
    logic             IFID_use_rs2;
    logic             IDEX_MemRead;
    logic [4:0]       IDEX_rd;
    logic             EXMEM_branch_taken;
    logic             EXMEM_mem_access;
    logic             mem_ready;

    logic             PC_Write;
    logic             IFID_Write;
    logic             IDEX_Write;
    logic             EXMEM_Write;
    logic             IFID_Flush;
    logic             IDEX_Flush;
    logic             EXMEM_Flush;
    logic             MEMWB_Bubble;
    logic             mem_timeout;
    logic [1:0]       state;
    logic [CNT_W-1:0] stall_count;
    logic [CNT_W-1:0] flush_count;

    modport master (
        output IFID_rs1, IFID_rs2, IFID_use_rs1, IFID_use_rs2, IDEX_MemRead, IDEX_rd,
               EXMEM_branch_taken, EXMEM_mem_access, mem_ready,
        input  PC_Write, IFID_Write, IDEX_Write, EXMEM_Write, IFID_Flush, IDEX_Flush,
               EXMEM_Flush, MEMWB_Bubble, mem_timeout, state, stall_count, flush_count
    );

    modport slave (
        input  IFID_rs1, IFID_rs2, IFID_use_rs1, IFID_use_rs2, IDEX_MemRead, IDEX_rd,
               EXMEM_branch_taken, EXMEM_mem_access, mem_ready,
        output PC_Write, IFID_Write, IDEX_Write, EXMEM_Write, IFID_Flush, IDEX_Flush,
               EXMEM_Flush, MEMWB_Bubble, mem_timeout, state, stall_count, flush_count
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller: load-use stalls, taken-branch flushes, data-memory wait freezes with
// timeout detection, and saturating stall/flush event counters.
module pipeline_hazard_ctrl #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    pipeline_hazard_ctrl_if.slave hz
);
    typedef enum logic [1:0] {
        S_RUN  = 2'd0,
        S_WAIT = 2'd1,
        S_ERR  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(TIMEOUT - 1);

    state_t           state, next_state;
    logic [CNT_W-1:0] wait_cnt;
    logic             mem_timeout;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;
    logic             freeze;
    logic             load_use;
    logic             do_stall;
    logic             do_flush;

    assign freeze   = hz.EXMEM_mem_access & ~hz.mem_ready;
    assign load_use = hz.IDEX_MemRead && (hz.IDEX_rd != 5'd0) &&
                      (((hz.IDEX_rd == hz.IFID_rs1) && hz.IFID_use_rs1) ||
                       ((hz.IDEX_rd == hz.IFID_rs2) && hz.IFID_use_rs2));

    always_ff @(posedge clk) begin
        if (reset) state <= S_RUN;
        else       state <= next_state;
    end

    // Priority chain: only the highest active condition shapes the control outputs.
    always_comb begin
        hz.PC_Write     = 1'b1;
        hz.IFID_Write   = 1'b1;
        hz.IDEX_Write   = 1'b1;
        hz.EXMEM_Write  = 1'b1;
        hz.IFID_Flush   = 1'b0;
        hz.IDEX_Flush   = 1'b0;
        hz.EXMEM_Flush  = 1'b0;
        hz.MEMWB_Bubble = 1'b0;
        do_stall        = 1'b0;
        do_flush        = 1'b0;
        next_state      = state;

        if (reset) begin
            hz.PC_Write     = 1'b0;
            hz.IFID_Write   = 1'b0;
            hz.IDEX_Write   = 1'b0;
            hz.EXMEM_Write  = 1'b0;
            hz.IFID_Flush   = 1'b1;
            hz.IDEX_Flush   = 1'b1;
            hz.EXMEM_Flush  = 1'b1;
            hz.MEMWB_Bubble = 1'b1;
        end else if (state == S_ERR || freeze) begin
            hz.PC_Write     = 1'b0;
            hz.IFID_Write   = 1'b0;
            hz.IDEX_Write   = 1'b0;
            hz.EXMEM_Write  = 1'b0;
            hz.MEMWB_Bubble = 1'b1;
            do_stall        = (state != S_ERR);
        end else if (hz.EXMEM_branch_taken) begin
            hz.IFID_Flush   = 1'b1;
            hz.IDEX_Flush   = 1'b1;
            hz.EXMEM_Flush  = 1'b1;
            do_flush        = 1'b1;
        end else if (load_use) begin
            hz.PC_Write     = 1'b0;
            hz.IFID_Write   = 1'b0;
            hz.IDEX_Flush   = 1'b1;
            do_stall        = 1'b1;
        end

        case (state)
            S_RUN:   if (freeze) next_state = S_WAIT;
            S_WAIT:  if (!freeze)                 next_state = S_RUN;
                     else if (wait_cnt == WAIT_LAST) next_state = S_ERR;
            S_ERR:   next_state = S_ERR;
            default: next_state = S_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt    <= '0;
            mem_timeout <= 1'b0;
            stall_cnt   <= '0;
            flush_cnt   <= '0;
        end else begin
            if (state == S_RUN && next_state == S_WAIT)
                wait_cnt <= CNT_W'(1);
            else if (state == S_WAIT && next_state == S_WAIT)
                wait_cnt <= wait_cnt + CNT_W'(1);
            else if (state == S_WAIT)
                wait_cnt <= '0;

            if (state == S_WAIT && next_state == S_ERR)
                mem_timeout <= 1'b1;

            if (do_stall && stall_cnt != '1) stall_cnt <= stall_cnt + CNT_W'(1);
            if (do_flush && flush_cnt != '1) flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end

    assign hz.state       = state;
    assign hz.mem_timeout = mem_timeout;
    assign hz.stall_count = stall_cnt;
    assign hz.flush_count = flush_cnt;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: vector table for the combinational priority chain
// plus hand-written sequences for waits, timeout, reset, branch-under-freeze and saturation.
module tb_pipeline_hazard_ctrl;
    localparam int TIMEOUT = 4;
    localparam int CNT_W   = 4;

    // Output pattern: {PC_W, IFID_W, IDEX_W, EXMEM_W, IFID_F, IDEX_F, EXMEM_F, MEMWB_Bubble}
    localparam logic [7:0] DEF = 8'b1111_0000;
    localparam logic [7:0] STL = 8'b0011_0100;
    localparam logic [7:0] FLS = 8'b1111_1110;
    localparam logic [7:0] FRZ = 8'b0000_0001;
    localparam logic [7:0] RST = 8'b0000_1111;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl_if #(.CNT_W(CNT_W)) hif ();

    pipeline_hazard_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .hz    (hif.slave)
    );

    typedef struct {
        logic [4:0] rs1, rs2, rd;
        logic       use1, use2, memread, br, acc, ready;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[14];

    function automatic vec_t mk(input logic [4:0] rs1, rs2, rd, input logic use1, use2,
                                input logic memread, br, acc, ready, input logic [7:0] exp);
        vec_t v;
        v.rs1 = rs1; v.rs2 = rs2; v.rd = rd; v.use1 = use1; v.use2 = use2;
        v.memread = memread; v.br = br; v.acc = acc; v.ready = ready; v.exp = exp;
        return v;
    endfunction

    function automatic logic [7:0] outs();
        return {hif.PC_Write, hif.IFID_Write, hif.IDEX_Write, hif.EXMEM_Write,
                hif.IFID_Flush, hif.IDEX_Flush, hif.EXMEM_Flush, hif.MEMWB_Bubble};
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        hif.IFID_rs1           = v.rs1;
        hif.IFID_rs2           = v.rs2;
        hif.IDEX_rd            = v.rd;
        hif.IFID_use_rs1       = v.use1;
        hif.IFID_use_rs2       = v.use2;
        hif.IDEX_MemRead       = v.memread;
        hif.EXMEM_branch_taken = v.br;
        hif.EXMEM_mem_access   = v.acc;
        hif.mem_ready          = v.ready;
    endtask

    task automatic set_idle();
        drive(mk(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, DEF));
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        set_idle();
        @(negedge clk);
        reset = 1'b0;
    endtask

    vec_t lu, fz, fzbr, nolu;
    int   exp_stall, exp_flush;

    initial begin
        lu   = mk(5'd5, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, STL);
        nolu = mk(5'd5, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, DEF);
        fz   = mk(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, FRZ);
        fzbr = mk(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, FRZ);

        vecs[0]  = mk(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, DEF);
        vecs[1]  = mk(5'd5, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, STL);
        vecs[2]  = mk(5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, DEF);
        vecs[3]  = mk(5'd1, 5'd7, 5'd7, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, STL);
        vecs[4]  = mk(5'd1, 5'd7, 5'd7, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, DEF);
        vecs[5]  = mk(5'd9, 5'd0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, DEF);
        vecs[6]  = mk(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, FLS);
        vecs[7]  = mk(5'd5, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, FLS);
        vecs[8]  = mk(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, FRZ);
        vecs[9]  = mk(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, FRZ);
        vecs[10] = mk(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, DEF);
        vecs[11] = mk(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, FLS);
        vecs[12] = mk(5'd3, 5'd3, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, DEF);
        vecs[13] = mk(5'd3, 5'd0, 5'd3, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, FRZ);

        // Reset behaviour
        set_idle();
        @(negedge clk);
        chk("reset_outs", int'(outs()), int'(RST));
        @(negedge clk);
        chk("reset_state", int'(hif.state), 0);
        chk("reset_timeout", int'(hif.mem_timeout), 0);
        chk("reset_stall", int'(hif.stall_count), 0);
        chk("reset_flush", int'(hif.flush_count), 0);
        reset = 1'b0;
        #1 chk("idle_outs", int'(outs()), int'(DEF));

        // Vector table
        exp_stall = 0;
        exp_flush = 0;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            drive(vecs[i]);
            #1 chk($sformatf("vec%0d", i), int'(outs()), int'(vecs[i].exp));
            if (vecs[i].exp[7] == 1'b0) exp_stall++;
            if (vecs[i].exp[1] == 1'b1) exp_flush++;
        end
        @(negedge clk);
        set_idle();
        chk("table_stall_count", int'(hif.stall_count), exp_stall);
        chk("table_flush_count", int'(hif.flush_count), exp_flush);

        // Load-use lasts one cycle once the bubble clears IDEX_MemRead; rd=0 never stalls
        do_reset();
        drive(lu);
        #1 chk("lu_outs", int'(outs()), int'(STL));
        @(negedge clk);
        drive(nolu);
        #1 chk("lu_after_bubble", int'(outs()), int'(DEF));
        chk("lu_stall_count", int'(hif.stall_count), 1);
        @(negedge clk);
        drive(mk(5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, DEF));
        #1 chk("lu_rd0_outs", int'(outs()), int'(DEF));
        @(negedge clk);
        chk("lu_rd0_stall", int'(hif.stall_count), 1);

        // Three-cycle memory wait
        do_reset();
        for (int i = 0; i < 3; i++) begin
            if (i > 0) @(negedge clk);
            drive(fz);
            #1 chk($sformatf("wait_outs%0d", i), int'(outs()), int'(FRZ));
            chk($sformatf("wait_state%0d", i), int'(hif.state), (i == 0) ? 0 : 1);
        end
        @(negedge clk);
        chk("wait_state_end", int'(hif.state), 1);
        chk("wait_stall_count", int'(hif.stall_count), 3);
        hif.mem_ready = 1'b1;
        #1 chk("wait_release_outs", int'(outs()), int'(DEF));
        @(negedge clk);
        chk("wait_back_run", int'(hif.state), 0);
        set_idle();

        // Timeout after TIMEOUT freeze edges, frozen until reset
        do_reset();
        drive(fz);
        for (int i = 0; i < TIMEOUT; i++) @(negedge clk)
            if (i == TIMEOUT - 2) begin
                chk("to_pre_state", int'(hif.state), 1);
                chk("to_pre_flag", int'(hif.mem_timeout), 0);
            end
        chk("to_state", int'(hif.state), 2);
        chk("to_flag", int'(hif.mem_timeout), 1);
        chk("to_stall_count", int'(hif.stall_count), TIMEOUT);
        hif.mem_ready = 1'b1;
        #1 chk("err_outs_ready", int'(outs()), int'(FRZ));
        @(negedge clk);
        set_idle();
        hif.EXMEM_branch_taken = 1'b1;
        #1 chk("err_outs_branch", int'(outs()), int'(FRZ));
        @(negedge clk);
        chk("err_held", int'(hif.state), 2);
        chk("err_no_flush_count", int'(hif.flush_count), 0);
        set_idle();
        reset = 1'b1;
        #1 chk("err_reset_outs", int'(outs()), int'(RST));
        @(negedge clk);
        reset = 1'b0;
        chk("err_cleared_state", int'(hif.state), 0);
        chk("err_cleared_flag", int'(hif.mem_timeout), 0);
        chk("err_cleared_stall", int'(hif.stall_count), 0);

        // Branch held under freeze fires on release
        do_reset();
        for (int i = 0; i < 2; i++) begin
            if (i > 0) @(negedge clk);
            drive(fzbr);
            #1 chk($sformatf("fzbr_outs%0d", i), int'(outs()), int'(FRZ));
        end
        @(negedge clk);
        hif.mem_ready = 1'b1;
        #1 chk("fzbr_release", int'(outs()), int'(FLS));
        @(negedge clk);
        set_idle();
        chk("fzbr_flush_count", int'(hif.flush_count), 1);
        chk("fzbr_stall_count", int'(hif.stall_count), 2);
        chk("fzbr_state", int'(hif.state), 0);

        // Reset mid-WAIT clears the wait counter
        do_reset();
        drive(fz);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        #1 chk("midwait_reset_outs", int'(outs()), int'(RST));
        @(negedge clk);
        reset = 1'b0;
        chk("midwait_state", int'(hif.state), 0);
        repeat (3) @(negedge clk);
        chk("midwait_rewait_state", int'(hif.state), 1);
        chk("midwait_rewait_flag", int'(hif.mem_timeout), 0);
        set_idle();

        // Stall counter saturation
        do_reset();
        drive(lu);
        repeat (20) @(negedge clk);
        chk("sat_stall_count", int'(hif.stall_count), 15);
        set_idle();
        @(negedge clk);
        chk("sat_stall_hold", int'(hif.stall_count), 15);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
